alu_rr_arbiter: RTL and testbench
=================================

# alu_rr_arbiter

Shares a single combinational `alu_riscv` instance between two independent requesters, such as a core datapath and a debug/self-test port. It uses round-robin arbitration and valid/ready handshakes on both the request and response sides. Operands are registered before the ALU and the result is registered after it. Each accepted operation therefore produces exactly one response, tagged to the requester that issued it. It sits between the requesters and the ALU; no requester drives `alu_riscv` directly.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand/result width; must match `alu_riscv`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk_i` in 1: clock.
  - `rst_i` in 1: asynchronous, active-high reset.
- Request side:
  - `req_valid_i` in 2: request valid, bit k = requester k.
  - `req_ready_o` out 2: request accepted this cycle, one-hot or zero.
  - `req_op_i` in 2x5, packed `[1:0][4:0]`: ALU opcode per requester (`alu_opcodes_pkg` encoding).
  - `req_a_i` in 2xDATA_WIDTH: operand A per requester.
  - `req_b_i` in 2xDATA_WIDTH: operand B per requester.
- Response side:
  - `rsp_valid_o` out 2: response valid for requester k, one-hot or zero.
  - `rsp_ready_i` in 2: requester k accepts its response.
  - `rsp_result_o` out DATA_WIDTH: shared result bus, valid where `rsp_valid_o` is set.
  - `rsp_flag_o` out 1: shared ALU flag, qualified the same way.
- Status:
  - `busy_o` out 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - With no `req_valid_i`, stay in IDLE.
  - Otherwise pick the winner `g`:
    - If exactly one request is valid, `g` is that requester.
    - If both are valid, `g = prio_q`.
  - `req_ready_o[g]` = 1 combinationally in the same cycle.
  - Capture `op_q`, `a_q`, `b_q` from requester g and `gnt_q <= g`, then go to EXEC.
- EXEC:
  - `alu_riscv` is driven from `op_q/a_q/b_q`.
  - Capture `res_q <= result_o` and `flag_q <= flag_o`, then go to RESP.
- RESP:
  - `rsp_valid_o[gnt_q]` = 1; `rsp_result_o = res_q`; `rsp_flag_o = flag_q`.
  - Hold all three stable until `rsp_ready_i[gnt_q]`.
  - On that handshake: `prio_q <= ~gnt_q`, go to IDLE.
  - `rsp_ready_i` for the non-granted requester is ignored.
- `req_ready_o` is 0 in EXEC and RESP. The arbiter has one operation outstanding at a time and does no pipelining.
- Round-robin: `prio_q` toggles only on a completed response. The last-served requester always has lower priority on the next conflict, so neither requester can starve the other.
- Requests must hold valid and payload until ready. A request dropped before it is accepted is simply not served; the arbiter has no error behaviour for this.
- `rsp_result_o` and `rsp_flag_o` show `res_q`/`flag_q` at all times. They are meaningful only while `rsp_valid_o` is set.

## Timing
- Reset (async assert):
  - state = IDLE, `prio_q` = 0, `gnt_q` = 0, `op_q/a_q/b_q/res_q/flag_q` = 0.
  - `req_ready_o` = 0, `rsp_valid_o` = 0, `rsp_result_o` = 0, `rsp_flag_o` = 0, `busy_o` = 0.
- Reset mid-operation: any in-flight operation is discarded without a response, and `prio_q` returns to 0.
- Latency: accept handshake in cycle N gives `rsp_valid_o` high from cycle N+2.
  - With `rsp_ready_i` high, the response completes in N+2 and a new accept is possible in N+3.
  - Maximum throughput: one operation per 3 cycles.
- Backpressure: RESP lasts for any number of cycles. A new request arriving during EXEC/RESP waits until IDLE.
- A response handshake and a new request never complete in the same cycle.

## Structure
- `alu_arb_pkg`: `typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_t`.
- Opcode width and encodings come from the existing `alu_opcodes_pkg`.
- One sub-module: `alu_riscv`, instantiated once, with its inputs driven only from `op_q/a_q/b_q`.
- Arbitration, FSM and the response registers live in `alu_rr_arbiter`.

## Test plan
- **Single request:** only req0 valid with `ADD`, a=5, b=7; `rsp_ready_i`=2'b01.
  - `req_ready_o`=01 at N.
  - `rsp_valid_o`=01 at N+2 with result=12.
- **Conflict after reset:** both requesters valid from reset; req0 `SUB` 10-3, req1 `ADD` 1+1.
  - req0 is served first with result=7.
  - req1 is served next with result=2, accepted at N+3.
- **Fairness:** both valid continuously for 6 operations with `rsp_ready_i`=11.
  - Grants alternate 0,1,0,1,0,1.
  - Accepts occur every 3 cycles.
- **Backpressure:** hold `rsp_ready_i[g]`=0 for 5 cycles on a comparison op (a=3, b=9, flag=1).
  - `rsp_valid_o`, result and flag stay stable for the whole wait.
  - `req_ready_o` stays 0; releasing `rsp_ready_i` completes the response.
- **Wrong-port ready:** in RESP for req1, assert only `rsp_ready_i[0]`.
  - No completion occurs and `prio_q` is unchanged.
- **Reset mid-op:** assert `rst_i` during EXEC.
  - All outputs go to 0 immediately.
  - No response appears after release, and the next conflict grants req0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module      : alu_arb_pkg
// Description : State encoding and helpers for the two-port ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_t;

  localparam int NUM_REQ = 2;

  function automatic logic [NUM_REQ-1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_opcodes_pkg.sv
// ============================================================================
// Module      : alu_opcodes_pkg
// Description : Opcode width and encodings shared by alu_riscv and its users.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_opcodes_pkg;

  localparam int ALU_OP_WIDTH = 5;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 5'h00,
    ALU_SUB  = 5'h01,
    ALU_XOR  = 5'h02,
    ALU_OR   = 5'h03,
    ALU_AND  = 5'h04,
    ALU_SLL  = 5'h05,
    ALU_SRL  = 5'h06,
    ALU_SRA  = 5'h07,
    ALU_LT   = 5'h08,
    ALU_LTU  = 5'h09,
    ALU_GE   = 5'h0A,
    ALU_GEU  = 5'h0B,
    ALU_EQ   = 5'h0C,
    ALU_NE   = 5'h0D,
    ALU_SLT  = 5'h0E,
    ALU_SLTU = 5'h0F
  } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/alu_riscv.sv
// ============================================================================
// Module      : alu_riscv
// Description : Combinational RV32-style ALU; comparisons drive flag_o and the
//               result LSB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_riscv
  import alu_opcodes_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [DATA_WIDTH-1:0]   operand_a_i,
  input  logic [DATA_WIDTH-1:0]   operand_b_i,
  output logic [DATA_WIDTH-1:0]   result_o,
  output logic                    flag_o
);

  localparam int c_SHAMT_W = $clog2(DATA_WIDTH);

  logic [c_SHAMT_W-1:0] w_shamt;
  logic                 w_cmp;
  logic                 w_is_cmp;

  assign w_shamt = operand_b_i[c_SHAMT_W-1:0];

  always_comb begin
    w_cmp    = 1'b0;
    w_is_cmp = 1'b1;
    case (operator_i)
      ALU_LT, ALU_SLT:   w_cmp = $signed(operand_a_i) < $signed(operand_b_i);
      ALU_LTU, ALU_SLTU: w_cmp = operand_a_i < operand_b_i;
      ALU_GE:            w_cmp = $signed(operand_a_i) >= $signed(operand_b_i);
      ALU_GEU:           w_cmp = operand_a_i >= operand_b_i;
      ALU_EQ:            w_cmp = operand_a_i == operand_b_i;
      ALU_NE:            w_cmp = operand_a_i != operand_b_i;
      default:           w_is_cmp = 1'b0;
    endcase
  end

  always_comb begin
    result_o = '0;
    case (operator_i)
      ALU_ADD: result_o = operand_a_i + operand_b_i;
      ALU_SUB: result_o = operand_a_i - operand_b_i;
      ALU_XOR: result_o = operand_a_i ^ operand_b_i;
      ALU_OR:  result_o = operand_a_i | operand_b_i;
      ALU_AND: result_o = operand_a_i & operand_b_i;
      ALU_SLL: result_o = operand_a_i << w_shamt;
      ALU_SRL: result_o = operand_a_i >> w_shamt;
      ALU_SRA: result_o = $unsigned($signed(operand_a_i) >>> w_shamt);
      default: if (w_is_cmp) result_o = {{(DATA_WIDTH-1){1'b0}}, w_cmp};
    endcase
  end

  assign flag_o = w_cmp;

endmodule

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
// ============================================================================
// Module      : alu_rr_arbiter
// Description : Round-robin sharing of one alu_riscv between two requesters,
//               with registered operands/result and valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_arbiter
  import alu_opcodes_pkg::*;
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [1:0]                       req_valid_i,
  output logic [1:0]                       req_ready_o,
  input  logic [1:0][ALU_OP_WIDTH-1:0]     req_op_i,
  input  logic [1:0][DATA_WIDTH-1:0]       req_a_i,
  input  logic [1:0][DATA_WIDTH-1:0]       req_b_i,
  output logic [1:0]                       rsp_valid_o,
  input  logic [1:0]                       rsp_ready_i,
  output logic [DATA_WIDTH-1:0]            rsp_result_o,
  output logic                             rsp_flag_o,
  output logic                             busy_o
);

  alu_arb_state_t          r_state;
  logic                    r_prio;
  logic                    r_gnt;
  logic [ALU_OP_WIDTH-1:0] r_op;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [DATA_WIDTH-1:0]   r_res;
  logic                    r_flag;
  logic [1:0]              r_rsp_valid;

  logic                    w_gnt;
  logic [DATA_WIDTH-1:0]   w_alu_res;
  logic                    w_alu_flag;

  // Both valid: priority holder wins; otherwise the lone requester wins.
  assign w_gnt = (req_valid_i == 2'b11) ? r_prio : req_valid_i[1];

  // Ready is gated by reset so nothing is accepted while rst_i is held.
  assign req_ready_o = (!rst_i && r_state == IDLE && |req_valid_i) ? onehot2(w_gnt) : 2'b00;

  alu_riscv #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .operator_i  (r_op),
    .operand_a_i (r_a),
    .operand_b_i (r_b),
    .result_o    (w_alu_res),
    .flag_o      (w_alu_flag)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_gnt       <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_flag      <= 1'b0;
      r_rsp_valid <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid_i) begin
            r_op    <= req_op_i[w_gnt];
            r_a     <= req_a_i[w_gnt];
            r_b     <= req_b_i[w_gnt];
            r_gnt   <= w_gnt;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_res       <= w_alu_res;
          r_flag      <= w_alu_flag;
          r_rsp_valid <= onehot2(r_gnt);
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i[r_gnt]) begin
            r_rsp_valid <= 2'b00;
            r_prio      <= ~r_gnt;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_result_o = r_res;
  assign rsp_flag_o   = r_flag;
  assign busy_o       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
// ============================================================================
// Module      : tb_alu_rr_arbiter
// Description : Directed self-checking bench for the two-port ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rr_arbiter;
  import alu_opcodes_pkg::*;

  localparam int DATA_WIDTH = 32;

  logic                         clk_i = 1'b0;
  logic                         rst_i;
  logic [1:0]                   req_valid_i;
  logic [1:0]                   req_ready_o;
  logic [1:0][ALU_OP_WIDTH-1:0] req_op_i;
  logic [1:0][DATA_WIDTH-1:0]   req_a_i;
  logic [1:0][DATA_WIDTH-1:0]   req_b_i;
  logic [1:0]                   rsp_valid_o;
  logic [1:0]                   rsp_ready_i;
  logic [DATA_WIDTH-1:0]        rsp_result_o;
  logic                         rsp_flag_o;
  logic                         busy_o;

  int total = 0;
  int bad   = 0;

  alu_rr_arbiter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_flag_o   (rsp_flag_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 2'b11;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 2'b00;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_result",    rsp_result_o,     32'h0);
    chk("rst_flag",      32'(rsp_flag_o),  32'h0);
    chk("rst_busy",      32'(busy_o),      32'h0);
    rst_i       = 1'b0;
    req_valid_i = 2'b00;

    // Single request: req0 ADD 5+7
    tick();
    req_op_i[0] = ALU_ADD; req_a_i[0] = 32'd5; req_b_i[0] = 32'd7;
    req_valid_i = 2'b01; rsp_ready_i = 2'b01;
    #1;
    chk("single_accept", 32'(req_ready_o), 32'h1);
    chk("single_idle",   32'(busy_o),      32'h0);
    tick();
    req_valid_i = 2'b00;
    #1;
    chk("single_exec_ready", 32'(req_ready_o), 32'h0);
    chk("single_exec_busy",  32'(busy_o),      32'h1);
    chk("single_exec_valid", 32'(rsp_valid_o), 32'h0);
    tick(); #1;
    chk("single_rsp_valid",  32'(rsp_valid_o), 32'h1);
    chk("single_rsp_result", rsp_result_o,     32'd12);
    chk("single_rsp_flag",   32'(rsp_flag_o),  32'h0);
    tick(); #1;
    chk("single_done_valid", 32'(rsp_valid_o), 32'h0);
    chk("single_done_busy",  32'(busy_o),      32'h0);

    // Conflict after reset: req0 SUB 10-3, req1 ADD 1+1
    do_reset();
    req_op_i[0] = ALU_SUB; req_a_i[0] = 32'd10; req_b_i[0] = 32'd3;
    req_op_i[1] = ALU_ADD; req_a_i[1] = 32'd1;  req_b_i[1] = 32'd1;
    req_valid_i = 2'b11; rsp_ready_i = 2'b11;
    #1;
    chk("conf_first_grant", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = 2'b10;
    #1;
    chk("conf_exec_ready", 32'(req_ready_o), 32'h0);
    tick(); #1;
    chk("conf_rsp0_valid",  32'(rsp_valid_o), 32'h1);
    chk("conf_rsp0_result", rsp_result_o,     32'd7);
    tick(); #1;
    chk("conf_second_grant", 32'(req_ready_o), 32'h2);
    chk("conf_second_noval", 32'(rsp_valid_o), 32'h0);
    tick();
    req_valid_i = 2'b00;
    tick(); #1;
    chk("conf_rsp1_valid",  32'(rsp_valid_o), 32'h2);
    chk("conf_rsp1_result", rsp_result_o,     32'd2);
    tick(); #1;

    // Fairness: req0 XOR F0^0F=FF, req1 AND FF&3C=3C, both always valid
    req_op_i[0] = ALU_XOR; req_a_i[0] = 32'hF0; req_b_i[0] = 32'h0F;
    req_op_i[1] = ALU_AND; req_a_i[1] = 32'hFF; req_b_i[1] = 32'h3C;
    req_valid_i = 2'b11; rsp_ready_i = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("fair_grant%0d", k), 32'(req_ready_o), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick(); #1;
      chk($sformatf("fair_exec%0d", k), 32'(req_ready_o), 32'h0);
      tick(); #1;
      chk($sformatf("fair_rspv%0d", k), 32'(rsp_valid_o), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("fair_res%0d", k),  rsp_result_o,     (k % 2 == 0) ? 32'hFF : 32'h3C);
      tick(); #1;
    end
    req_valid_i = 2'b00;

    // Backpressure: req0 LT 3<9; req1 (SUB 20-5) waits during the stall
    tick();
    req_op_i[0] = ALU_LT;  req_a_i[0] = 32'd3;  req_b_i[0] = 32'd9;
    req_op_i[1] = ALU_SUB; req_a_i[1] = 32'd20; req_b_i[1] = 32'd5;
    req_valid_i = 2'b01; rsp_ready_i = 2'b00;
    #1;
    chk("bp_accept", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = 2'b10;
    tick(); #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k),  32'(rsp_valid_o), 32'h1);
      chk($sformatf("bp_result%0d", k), rsp_result_o,     32'h1);
      chk($sformatf("bp_flag%0d", k),   32'(rsp_flag_o),  32'h1);
      chk($sformatf("bp_ready%0d", k),  32'(req_ready_o), 32'h0);
      tick(); #1;
    end
    rsp_ready_i = 2'b01;
    #1;
    chk("bp_release_valid", 32'(rsp_valid_o), 32'h1);
    tick();
    rsp_ready_i = 2'b00;
    #1;
    chk("bp_done_valid", 32'(rsp_valid_o), 32'h0);
    chk("bp_next_grant", 32'(req_ready_o), 32'h2);

    // Wrong-port ready: req1 in RESP, only rsp_ready_i[0] asserted
    tick();
    req_valid_i = 2'b00;
    tick();
    rsp_ready_i = 2'b01;
    #1;
    chk("wp_rsp_result", rsp_result_o, 32'd15);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wp_hold%0d", k), 32'(rsp_valid_o), 32'h2);
      chk($sformatf("wp_busy%0d", k), 32'(busy_o),      32'h1);
      tick(); #1;
    end
    chk("wp_prio_kept", 32'(dut.r_prio), 32'h1);
    rsp_ready_i = 2'b10;
    tick(); #1;
    chk("wp_done_valid", 32'(rsp_valid_o), 32'h0);
    chk("wp_done_busy",  32'(busy_o),      32'h0);
    rsp_ready_i = 2'b00;

    // Reset mid-op: first give req1 priority, then kill a req1 op in EXEC
    req_op_i[0] = ALU_ADD; req_a_i[0] = 32'd40; req_b_i[0] = 32'd2;
    req_valid_i = 2'b01; rsp_ready_i = 2'b01;
    #1;
    chk("rm_pre_grant", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = 2'b00;
    tick(); tick(); #1;
    chk("rm_pre_done", 32'(busy_o), 32'h0);
    req_valid_i = 2'b10; rsp_ready_i = 2'b11;
    #1;
    chk("rm_req1_grant", 32'(req_ready_o), 32'h2);
    tick();
    req_valid_i = 2'b11;
    rst_i = 1'b1;
    #1;
    chk("rm_rst_ready",  32'(req_ready_o),  32'h0);
    chk("rm_rst_valid",  32'(rsp_valid_o),  32'h0);
    chk("rm_rst_result", rsp_result_o,      32'h0);
    chk("rm_rst_flag",   32'(rsp_flag_o),   32'h0);
    chk("rm_rst_busy",   32'(busy_o),       32'h0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("rm_after_grant", 32'(req_ready_o), 32'h1);
    chk("rm_after_valid", 32'(rsp_valid_o), 32'h0);
    tick();
    req_valid_i = 2'b00;
    #1;
    chk("rm_exec_valid", 32'(rsp_valid_o), 32'h0);
    tick(); #1;
    chk("rm_rsp_valid",  32'(rsp_valid_o), 32'h1);
    chk("rm_rsp_result", rsp_result_o,     32'd42);
    tick(); #1;
    chk("rm_end_busy", 32'(busy_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
